fire3_expand1_bias_sequencer: RTL and testbench
===============================================

Name: fire3_expand1_bias_sequencer

Overview:
- Post-accumulation stage for the fire3 expand1x1 layer.
- Takes raw 32-bit convolution accumulators streamed in channel order (0..NUM_CH-1 per output pixel) and adds the per-channel bias from the constant bias table, then applies ReLU, right-shift requantization and saturation.
- Emits activations downstream with a valid/ready handshake.
- A start/done FSM sequences one layer pass of NUM_PIXELS pixels.

Parameters:
- NUM_CH, 64, output channels per pixel; size of the bias table.
- ACC_W, 32, accumulator and bias width, signed two's complement.
- OUT_W, 16, output activation width.
- SHIFT, 8, arithmetic right shift applied after bias add.
- PIX_W, 16, width of the pixel-count configuration.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a pass. Ignored unless the FSM is in IDLE.
- num_pixels  in  PIX_W  pixel count for the pass; sampled on an accepted start.
- bias_mem  in  ACC_W x [0:NUM_CH-1]  constant per-channel signed bias table.
- in_valid  in  1  accumulator valid.
- in_ready  out  1  block accepts accumulator this cycle.
- in_acc  in  ACC_W  signed accumulator for the current channel.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  requantized activation, unsigned (ReLU result).
- out_ch  out  log2(NUM_CH)  channel index of out_data.
- out_last  out  1  high with the final channel of the final pixel.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when the pass completes.

Behaviour:
- Reset clears FSM, counters and both pipeline valids. All outputs are 0 during and after reset, including in_ready, out_valid, busy and done.
- Reset mid-pass aborts immediately; no done pulse is produced.
- FSM states:
  - IDLE: on start, latch num_pixels, clear ch_cnt and pix_cnt. Go to RUN, or to FLUSH if num_pixels==0.
  - RUN: accept accumulators. On acceptance of ch_cnt==NUM_CH-1 with pix_cnt==num_pixels-1, go to FLUSH.
  - FLUSH: wait until both pipeline stages are empty, then go to DONE.
  - DONE: assert done for one cycle, return to IDLE.
- Handshake:
  - adv = !s2_valid || out_ready.
  - in_ready = (state==RUN) && adv.
  - Transfer occurs when in_valid && in_ready.
  - out_valid = s2_valid. out_data, out_ch and out_last are held stable while out_valid && !out_ready.
- Counters:
  - ch_cnt increments per accepted input and wraps NUM_CH-1 -> 0.
  - On wrap, pix_cnt increments.
- Pipeline stage 1 (on transfer):
  - s1_sum = sext(in_acc) + sext(bias_mem[ch_cnt]), computed at ACC_W+1 bits so there is no overflow.
  - Also captures channel and last flag.
- Pipeline stage 2 (when adv):
  - s2_valid <= s1_valid.
  - r = (s1_sum < 0) ? 0 : s1_sum >>> SHIFT.
  - out_data = (r > 2^OUT_W-1) ? 2^OUT_W-1 : r[OUT_W-1:0].
- Stalls: s1 also holds when !adv.
- Latency: 2 cycles from input transfer to out_valid with out_ready held high. Throughput is 1 per cycle.
- Simultaneous events:
  - start during a non-IDLE state is ignored.
  - Output drain and new input in the same cycle are both allowed (full throughput).
- done is asserted the cycle after the last output transfer completes.
- busy is low only in IDLE.

Test Plan:
- Single pixel, out_ready=1, bias[0]=-321, in_acc=0x00010000, SHIFT=8 -> out_data=(65536-321)>>8=254, out_ch=0, 2-cycle latency; after 64 inputs out_last on ch 63, done pulses once, busy drops.
- ReLU and saturation: bias[3]=1169, in_acc=-5000 -> out_data=0; in_acc=0x7FFF0000 -> out_data=0xFFFF.
- Backpressure: 2 pixels, out_ready toggled 1/0 every cycle -> all 128 outputs delivered in order with channels 0..63 twice, no loss or duplication; data stable while stalled.
- num_pixels=0 -> start produces done 2 cycles later (IDLE->FLUSH->DONE) with zero out_valid.
- start pulsed again mid-RUN -> ignored; counts unchanged; a single done at the end.
- rst asserted at pixel 1 channel 20 -> next cycle all outputs 0, FSM IDLE, no done; a fresh start runs cleanly from ch 0.

Source files
------------

// File: rtl/fire3_expand1_bias_sequencer.sv
// fire3_expand1_bias_sequencer
// Post-accumulation stage for the fire3 expand1x1 layer. Raw convolution
// accumulators arrive in channel order (0..NUM_CH-1 per pixel). Each one gets
// its channel bias added, then ReLU, an arithmetic right shift and saturation
// to OUT_W bits. A start/done FSM sequences one pass of num_pixels pixels.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   start        one-cycle pulse, accepted only in IDLE
//   num_pixels   pixel count for the pass, latched on an accepted start
//   bias_mem     constant signed per-channel bias table
//   in_valid / in_ready / in_acc        accumulator input handshake
//   out_valid / out_ready / out_data    activation output handshake
//   out_ch       channel index of out_data
//   out_last     final channel of the final pixel
//   busy         high whenever the FSM is not idle
//   done         one-cycle pulse at the end of a pass
module fire3_expand1_bias_sequencer #(
    parameter int NUM_CH = 64,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 8,
    parameter int PIX_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [PIX_W-1:0]        num_pixels,
    input  logic signed [ACC_W-1:0] bias_mem [0:NUM_CH-1],
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [ACC_W-1:0] in_acc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [PIX_W-1:0] num_pix_q;
    logic [PIX_W-1:0] pix_cnt;
    logic [CH_W-1:0]  ch_cnt;

    logic                    s1_valid;
    logic signed [ACC_W:0]   s1_sum;
    logic [CH_W-1:0]         s1_ch;
    logic                    s1_last;

    logic                    s2_valid;
    logic [OUT_W-1:0]        s2_data;
    logic [CH_W-1:0]         s2_ch;
    logic                    s2_last;

    logic                    adv;
    logic                    xfer;
    logic                    ch_last;
    logic                    pix_last;
    logic signed [ACC_W:0]   shifted;
    logic [OUT_W-1:0]        req_data;

    // The whole pipeline moves forward whenever the output register is
    // empty or being drained this cycle.
    assign adv      = !s2_valid || out_ready;
    assign xfer     = in_valid && in_ready;
    assign ch_last  = (ch_cnt == CH_W'(NUM_CH - 1));
    assign pix_last = (pix_cnt == num_pix_q - PIX_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (num_pixels == '0) ? S_FLUSH : S_RUN;
                end
            end
            S_RUN: begin
                if (xfer && ch_last && pix_last) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!s1_valid && !s2_valid) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = (state == S_RUN) && adv;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        out_valid = s2_valid;
        out_data  = s2_data;
        out_ch    = s2_ch;
        out_last  = s2_last;
    end

    // Pass configuration and channel/pixel position of the next input
    always_ff @(posedge clk) begin
        if (rst) begin
            num_pix_q <= '0;
            pix_cnt   <= '0;
            ch_cnt    <= '0;
        end else if (state == S_IDLE && start) begin
            num_pix_q <= num_pixels;
            pix_cnt   <= '0;
            ch_cnt    <= '0;
        end else if (xfer) begin
            if (ch_last) begin
                ch_cnt  <= '0;
                pix_cnt <= pix_cnt + PIX_W'(1);
            end else begin
                ch_cnt  <= ch_cnt + CH_W'(1);
            end
        end
    end

    // Requantisation of the stage-1 sum: negative sums clamp to zero, large
    // positive results clamp to the top code.
    always_comb begin
        shifted  = s1_sum >>> SHIFT;
        req_data = shifted[OUT_W-1:0];
        if (s1_sum[ACC_W]) begin
            req_data = '0;
        end else if (|shifted[ACC_W:OUT_W]) begin
            req_data = '1;
        end
    end

    // Two-stage pipeline. The bias add is one bit wider than the operands so
    // it can never wrap. Both stages freeze together while the output stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_ch    <= '0;
            s1_last  <= 1'b0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_ch    <= '0;
            s2_last  <= 1'b0;
        end else if (adv) begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_sum  <= {in_acc[ACC_W-1], in_acc}
                         + {bias_mem[ch_cnt][ACC_W-1], bias_mem[ch_cnt]};
                s1_ch   <= ch_cnt;
                s1_last <= ch_last && pix_last;
            end
            s2_valid <= s1_valid;
            s2_data  <= req_data;
            s2_ch    <= s1_ch;
            s2_last  <= s1_last;
        end
    end

endmodule

// File: tb/tb_fire3_expand1_bias_sequencer.sv
// tb_fire3_expand1_bias_sequencer
// Self-checking bench for fire3_expand1_bias_sequencer. Every accepted
// accumulator pushes its expected activation onto a scoreboard queue; every
// cycle with out_valid is compared against the queue head, which is popped
// when downstream accepts.
module tb_fire3_expand1_bias_sequencer;

    localparam int NUM_CH = 64;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 16;
    localparam int SHIFT  = 8;
    localparam int PIX_W  = 16;

    typedef struct {
        logic [OUT_W-1:0] data;
        int               ch;
        logic             last;
        int               cyc;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [PIX_W-1:0]        num_pixels = '0;
    logic signed [ACC_W-1:0] bias_mem [0:NUM_CH-1];
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [ACC_W-1:0] in_acc = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [OUT_W-1:0]        out_data;
    logic [5:0]              out_ch;
    logic                    out_last;
    logic                    busy;
    logic                    done;

    int   num_checks = 0;
    int   num_fails  = 0;
    int   cyc        = 0;
    int   done_count = 0;
    int   cur_idx    = 0;
    int   cur_total  = 0;
    bit   bp_mode    = 1'b0;
    exp_t sb[$];

    fire3_expand1_bias_sequencer #(
        .NUM_CH (NUM_CH),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W),
        .SHIFT  (SHIFT),
        .PIX_W  (PIX_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_pixels (num_pixels),
        .bias_mem   (bias_mem),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_acc     (in_acc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Downstream readiness: always ready, or toggling every cycle under backpressure
    always @(posedge clk) begin
        #1;
        out_ready = bp_mode ? ~out_ready : 1'b1;
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        num_checks++;
        if (observed != expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Reference: bias add at full precision, ReLU, shift, saturate
    function automatic logic [OUT_W-1:0] refModel(input logic signed [ACC_W-1:0] acc,
                                                 input logic signed [ACC_W-1:0] b);
        longint s;
        s = longint'(acc) + longint'(b);
        if (s < 0) return '0;
        s = s >>> SHIFT;
        if (s > 65535) return 16'hFFFF;
        return s[OUT_W-1:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] genAcc(input int mode, input int pix, input int ch);
        if (mode == 0) return 32'sh0001_0000;
        if (mode == 1 && ch == 3 && pix == 0) return -32'sd5000;
        if (mode == 1 && ch == 3 && pix == 1) return 32'sh7FFF_0000;
        return $urandom;
    endfunction

    // Monitor / scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst) begin
            if (in_valid && in_ready) begin
                e.ch   = cur_idx % NUM_CH;
                e.data = refModel(in_acc, bias_mem[e.ch]);
                e.last = (cur_idx == cur_total - 1);
                e.cyc  = cyc;
                sb.push_back(e);
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out", 1, 0);
                end else begin
                    e = sb[0];
                    checkOutput("data", out_data, e.data);
                    checkOutput("ch", out_ch, e.ch);
                    checkOutput("last", out_last, e.last);
                    if (out_ready) begin
                        if (!bp_mode) checkOutput("latency", cyc - e.cyc, 2);
                        void'(sb.pop_front());
                    end
                end
            end
            if (done) done_count++;
        end
    end

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_in_ready"}, in_ready, 0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_out_data"}, out_data, 0);
        checkOutput({tag, "_out_ch"}, out_ch, 0);
        checkOutput({tag, "_out_last"}, out_last, 0);
    endtask

    // One layer pass. restart_at pulses a spurious start (with a different
    // pixel count) mid-run; abort_at resets the block instead of sending that input.
    task automatic applyStimulus(input int np, input int mode, input bit bp,
                                 input int restart_at, input int abort_at);
        bit accepted;
        int waited;
        bp_mode    = bp;
        done_count = 0;
        cur_total  = np * NUM_CH;
        num_pixels = PIX_W'(np);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int idx = 0; idx < np * NUM_CH; idx++) begin
            if (idx == abort_at) begin
                in_valid = 1'b0;
                rst      = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                sb.delete();
                checkIdleZero("abort");
                repeat (5) @(posedge clk);
                #1;
                checkOutput("abort_no_done", done_count, 0);
                return;
            end
            if (bp && (idx % 7) == 3) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            if (idx == restart_at) begin
                start      = 1'b1;
                num_pixels = PIX_W'(5);
            end
            cur_idx  = idx;
            in_acc   = genAcc(mode, idx / NUM_CH, idx % NUM_CH);
            in_valid = 1'b1;
            accepted = 1'b0;
            waited   = 0;
            while (!accepted && waited < 64) begin
                @(negedge clk);
                accepted = in_ready;
                @(posedge clk); #1;
                start = 1'b0;
                waited++;
            end
            if (!accepted) begin
                checkOutput("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        waited = 0;
        while (busy && waited < 400) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("busy_drop", busy, 0);
        checkOutput("done_pulses", done_count, 1);
        checkOutput("sb_drained", sb.size(), 0);
        bp_mode = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            bias_mem[i] = ACC_W'((i * 997) % 4000 - 2000);
        end
        bias_mem[0] = -32'sd321;
        bias_mem[3] = 32'sd1169;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkIdleZero("reset");

        // Single pixel, constant accumulator; ch0 expects 254
        applyStimulus(1, 0, 1'b0, -1, -1);

        // ReLU clamp and saturation on channel 3, random elsewhere
        applyStimulus(2, 1, 1'b0, -1, -1);

        // Backpressure with random data and input gaps
        applyStimulus(2, 2, 1'b1, -1, -1);
        repeat (2) @(posedge clk);
        #1;

        // Zero-pixel pass: done two cycles after start, no output
        done_count = 0;
        num_pixels = '0;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("np0_busy", busy, 1);
        checkOutput("np0_done_early", done, 0);
        @(posedge clk); #1;
        checkOutput("np0_done", done, 1);
        @(posedge clk); #1;
        checkOutput("np0_done_clear", done, 0);
        checkOutput("np0_idle", busy, 0);
        checkOutput("np0_pulses", done_count, 1);
        checkOutput("np0_no_out", sb.size(), 0);

        // Spurious start mid-run must be ignored
        applyStimulus(2, 2, 1'b0, 70, -1);

        // Reset at pixel 1 channel 20, then a clean pass from channel 0
        applyStimulus(3, 2, 1'b0, -1, NUM_CH + 20);
        applyStimulus(1, 2, 1'b0, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
